// File: rtl/bpsk_tx_controller.sv
// bpsk_tx_controller: frame sequencer feeding bpsk_modulator one word per
// word period: preamble, sync, length, payload and, when the build macro
// BPSK_TX_CHECKSUM_EN is defined, a trailing checksum word.
// Ports: clk, arst_n (async, active low), start, frame_len[7:0],
//   s_data/s_valid/s_ready payload stream, mod_en, mod_in, word_strobe,
//   busy, underrun (sticky), done (1-cycle end pulse).
module bpsk_tx_controller #(
  parameter int WORD_W = 9,
  parameter int WORD_CYCLES = 2048,
  parameter int PREAMBLE_LEN = 4,
  parameter logic [WORD_W-1:0] PREAMBLE_WD = 9'h155,
  parameter logic [WORD_W-1:0] SYNC_WD = 9'h1E3
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [7:0]        frame_len,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mod_en,
  output logic [WORD_W-1:0] mod_in,
  output logic              word_strobe,
  output logic              busy,
  output logic              underrun,
  output logic              done
);

  localparam int TW = $clog2(WORD_CYCLES);
  localparam int PW_MIN = $clog2(PREAMBLE_LEN + 1);
  localparam int PW = (PW_MIN > 3) ? PW_MIN : 3;
  localparam logic [TW-1:0] TMAX = TW'(WORD_CYCLES - 1);
  localparam logic [PW-1:0] PLAST = PW'(PREAMBLE_LEN - 1);

`ifdef BPSK_TX_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SYNC, S_LEN, S_PAY, S_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SYNC, S_LEN, S_PAY
  } state_t;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TW-1:0]     r_timer;
  logic [PW-1:0]     r_pre_cnt;
  logic [7:0]        r_len;
  logic [7:0]        r_pay_cnt;
  logic [7:0]        r_fetch_cnt;
  logic [WORD_W-1:0] r_hold;
  logic              r_hold_vld;
  logic [WORD_W-1:0] r_mod_in;
  logic              r_mod_en;
  logic              r_strobe;
  logic              r_underrun;
  logic              r_done;
`ifdef BPSK_TX_CHECKSUM_EN
  logic [WORD_W-1:0] r_csum;
`endif

  logic              w_busy;
  logic              w_bnd;
  logic              w_ready;
  logic              w_hs;
  logic              w_start;
  logic              w_miss;
  logic [WORD_W-1:0] w_pay_word;
  logic              w_load;
  logic              w_end;
  logic              w_pay;
  logic [WORD_W-1:0] w_word;

  assign w_busy  = (r_state != S_IDLE);
  assign w_bnd   = w_busy && (r_timer == TMAX);
  assign w_start = (r_state == S_IDLE) && start;
  assign w_ready = w_busy && !r_hold_vld
                && (r_fetch_cnt < r_len);
  assign w_hs    = w_ready && s_valid;

  // Slot source: held word, else same-cycle
  // bypass, else a zero fill word.
  assign w_miss     = !r_hold_vld && !w_hs;
  assign w_pay_word = r_hold_vld ? r_hold :
                      (w_hs ? s_data : '0);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_end       = 1'b0;
    w_pay       = 1'b0;
    w_word      = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_PRE;
          w_load      = 1'b1;
          w_word      = PREAMBLE_WD;
        end
      end
      S_PRE: begin
        if (w_bnd) begin
          w_load = 1'b1;
          if (r_pre_cnt == PLAST) begin
            w_state_nxt = S_SYNC;
            w_word      = SYNC_WD;
          end else begin
            w_word = PREAMBLE_WD;
          end
        end
      end
      S_SYNC: begin
        if (w_bnd) begin
          w_state_nxt = S_LEN;
          w_load      = 1'b1;
          w_word      = WORD_W'(r_len);
        end
      end
      S_LEN, S_PAY: begin
        if (w_bnd) begin
          if (r_pay_cnt != r_len) begin
            w_state_nxt = S_PAY;
            w_load      = 1'b1;
            w_pay       = 1'b1;
            w_word      = w_pay_word;
          end else begin
`ifdef BPSK_TX_CHECKSUM_EN
            w_state_nxt = S_CSUM;
            w_load      = 1'b1;
            w_word      = r_csum;
`else
            w_state_nxt = S_IDLE;
            w_end       = 1'b1;
`endif
          end
        end
      end
`ifdef BPSK_TX_CHECKSUM_EN
      S_CSUM: begin
        if (w_bnd) begin
          w_state_nxt = S_IDLE;
          w_end       = 1'b1;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_timer   <= '0;
      r_pre_cnt <= '0;
    end else begin
      if (!w_busy || w_bnd) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end
      if (!w_busy) begin
        r_pre_cnt <= '0;
      end else if (r_state == S_PRE && w_bnd) begin
        r_pre_cnt <= r_pre_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mod_in <= '0;
      r_mod_en <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_strobe <= w_load;
      r_done   <= w_end;
      if (w_load) begin
        r_mod_in <= w_word;
        r_mod_en <= 1'b1;
      end else if (w_end) begin
        r_mod_in <= '0;
        r_mod_en <= 1'b0;
      end
    end
  end

  // An empty slot still consumes one fetch so
  // late data lands in the following slot.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_len       <= '0;
      r_pay_cnt   <= '0;
      r_fetch_cnt <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (w_start) begin
      r_len       <= frame_len;
      r_pay_cnt   <= '0;
      r_fetch_cnt <= '0;
      r_hold_vld  <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (w_pay) begin
      r_pay_cnt <= r_pay_cnt + 8'd1;
      if (r_hold_vld) begin
        r_hold_vld <= 1'b0;
      end else begin
        r_fetch_cnt <= r_fetch_cnt + 8'd1;
        if (w_miss) begin
          r_underrun <= 1'b1;
        end
      end
    end else if (w_hs) begin
      r_hold      <= s_data;
      r_hold_vld  <= 1'b1;
      r_fetch_cnt <= r_fetch_cnt + 8'd1;
    end
  end

`ifdef BPSK_TX_CHECKSUM_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= WORD_W'(frame_len);
    end else if (w_pay) begin
      r_csum <= r_csum + w_word;
    end
  end
`endif

  assign s_ready     = w_ready;
  assign mod_en      = r_mod_en;
  assign mod_in      = r_mod_in;
  assign word_strobe = r_strobe;
  assign busy        = w_busy;
  assign underrun    = r_underrun;
  assign done        = r_done;

endmodule

// File: tb/tb_bpsk_tx_controller.sv
// tb_bpsk_tx_controller: directed frame table, hand sequences and random
// traffic against a word-index reference model of the frame sequencer.
module tb_bpsk_tx_controller;
  localparam int WC = 8;
  localparam int PL = 2;
`ifdef BPSK_TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam logic [8:0] PRE = 9'h155;
  localparam logic [8:0] SYN = 9'h1E3;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic [8:0] s_data = 9'd0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       mod_en;
  logic [8:0] mod_in;
  logic       word_strobe;
  logic       busy;
  logic       underrun;
  logic       done;

  always #5 clk = ~clk;

  bpsk_tx_controller #(
    .WORD_W(9),
    .WORD_CYCLES(WC),
    .PREAMBLE_LEN(PL),
    .PREAMBLE_WD(PRE),
    .SYNC_WD(SYN)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .start(start),
    .frame_len(frame_len),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .mod_en(mod_en),
    .mod_in(mod_in),
    .word_strobe(word_strobe),
    .busy(busy),
    .underrun(underrun),
    .done(done)
  );

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  int t0 = 0;
  int en_cnt = 0;
  int done_lat = -1;
  bit ready_seen = 1'b0;
  bit gate = 1'b0;
  logic [8:0] src[$];
  logic [8:0] got_words[$];

  // reference model: word index within frame + cycle within word
  bit         m_busy;
  int         m_t, m_w, m_n, m_fetched, m_sum;
  logic [8:0] m_q[$];
  logic       m_en, m_stb, m_done, m_und;
  logic [8:0] m_word;

  typedef struct packed {
    logic [7:0]      n;
    logic [2:0][8:0] d;
    logic [3:0]      nw;
    logic [6:0][8:0] w;
    logic [8:0]      cs;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_busy && (m_q.size() == 0) && (m_fetched < m_n);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_t = 0; m_w = 0; m_n = 0; m_fetched = 0; m_sum = 0;
    m_q.delete();
    m_en = 0; m_stb = 0; m_done = 0; m_und = 0; m_word = '0;
  endtask

  task automatic model_step();
    bit hs;
    bit pay;
    int total;
    hs = m_ready() && s_valid;
    pay = 0;
    m_stb = 0;
    m_done = 0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_t = 0; m_w = 0; m_n = int'(frame_len);
        m_fetched = 0; m_sum = 0; m_q.delete(); m_und = 0;
        m_en = 1; m_word = PRE; m_stb = 1;
      end
    end else if (m_t != WC - 1) begin
      m_t++;
      if (hs) begin
        m_q.push_back(s_data);
        m_fetched++;
      end
    end else begin
      total = PL + 2 + m_n + CS;
      m_t = 0;
      m_w++;
      if (m_w == total) begin
        m_busy = 0; m_en = 0; m_word = '0; m_done = 1;
      end else begin
        m_stb = 1;
        if (m_w < PL) m_word = PRE;
        else if (m_w == PL) m_word = SYN;
        else if (m_w == PL + 1) m_word = 9'(m_n);
        else if (m_w < PL + 2 + m_n) begin
          pay = 1;
          if (m_q.size() > 0) m_word = m_q.pop_front();
          else if (hs) begin
            m_word = s_data;
            m_fetched++;
          end else begin
            m_word = '0;
            m_und = 1;
            m_fetched++;
          end
          m_sum += int'(m_word);
        end else m_word = 9'((m_n + m_sum) % 512);
      end
      if (hs && !pay) begin
        m_q.push_back(s_data);
        m_fetched++;
      end
    end
  endtask

  task automatic tick();
    bit hs;
    s_valid = gate && (src.size() > 0);
    s_data = (src.size() > 0) ? src[0] : 9'($urandom);
    hs = s_valid && s_ready;
    if (!arst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    if (hs) void'(src.pop_front());
    cyc++;
    check($sformatf("cyc%0d_outs", cyc),
          32'({mod_en, mod_in, word_strobe, busy, underrun, done, s_ready}),
          32'({m_en, m_word, m_stb, m_busy, m_und, m_done, m_ready()}));
    if (word_strobe) got_words.push_back(mod_in);
    if (mod_en) en_cnt++;
    if (done && done_lat < 0) done_lat = cyc - t0;
    if (s_ready) ready_seen = 1;
  endtask

  task automatic begin_frame();
    got_words.delete();
    en_cnt = 0;
    done_lat = -1;
    ready_seen = 0;
    t0 = cyc;
  endtask

  function automatic vec_t mk(input logic [7:0] n, input logic [8:0] d0,
      input logic [8:0] d1, input logic [8:0] d2, input logic [3:0] nw,
      input logic [8:0] w3, input logic [8:0] w4, input logic [8:0] w5,
      input logic [8:0] w6, input logic [8:0] cs);
    vec_t v;
    v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.nw = nw;
    v.w[0] = PRE; v.w[1] = PRE; v.w[2] = SYN;
    v.w[3] = w3; v.w[4] = w4; v.w[5] = w5; v.w[6] = w6;
    v.cs = cs;
    return v;
  endfunction

  task automatic check_words(input string tag, input int nw,
                             input logic [8:0] exp[8]);
    logic [8:0] g;
    check({tag, "_nwords"}, 32'(got_words.size()), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      g = (i < got_words.size()) ? got_words[i] : 9'h1ff;
      check($sformatf("%s_word%0d", tag, i), 32'(g), 32'(exp[i]));
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit pulses);
    int nw;
    int lim;
    logic [8:0] exp[8];
    src.delete();
    for (int i = 0; i < int'(v.n); i++) src.push_back(v.d[i]);
    gate = 1;
    frame_len = v.n;
    start = 1;
    begin_frame();
    tick();
    start = 0;
    frame_len = 8'($urandom);
    check({tag, "_start_lat"}, 32'({mod_en, word_strobe, busy}), 32'h7);
    check({tag, "_und_clr"}, 32'(underrun), 32'h0);
    nw = int'(v.nw) + CS;
    lim = nw * WC + 1;
    for (int k = 1; done_lat < 0 && k < lim + 20; k++) begin
      start = pulses && (k == 20 || k == lim - 1);
      if (start) frame_len = 8'd5;
      tick();
    end
    start = 0;
    if (done_lat < 0) check({tag, "_timeout"}, 32'h0, 32'h1);
    for (int i = 0; i < 8; i++)
      exp[i] = (i < int'(v.nw)) ? v.w[i] : v.cs;
    check_words(tag, nw, exp);
    check({tag, "_en_cycles"}, 32'(en_cnt), 32'(nw * WC));
    check({tag, "_done_lat"}, 32'(done_lat), 32'(lim));
    check({tag, "_underrun"}, 32'(underrun), 32'h0);
    check({tag, "_ready_seen"}, 32'(ready_seen), 32'(v.n != 0));
    tick();
    check({tag, "_idle_after"}, 32'({busy, mod_en}), 32'h0);
  endtask

  initial begin
    logic [8:0] uexp[8];
    bit pushed;
    int thr;
    vecs[0] = mk(8'd3, 9'h101, 9'h0AA, 9'h1FF, 4'd7,
                 9'h003, 9'h101, 9'h0AA, 9'h1FF, 9'h1AD);
    vecs[1] = mk(8'd0, 9'h000, 9'h000, 9'h000, 4'd4,
                 9'h000, 9'h000, 9'h000, 9'h000, 9'h000);
    vecs[2] = mk(8'd1, 9'h0FF, 9'h000, 9'h000, 4'd5,
                 9'h001, 9'h0FF, 9'h000, 9'h000, 9'h100);
    vecs[3] = mk(8'd2, 9'h1FF, 9'h1FF, 9'h000, 4'd6,
                 9'h002, 9'h1FF, 9'h1FF, 9'h000, 9'h000);
    model_reset();

    // reset held with toggling inputs
    #1 arst_n = 0;
    for (int k = 0; k < 6; k++) begin
      start = 1'($urandom);
      frame_len = 8'($urandom);
      gate = 1'($urandom);
      src.push_back(9'($urandom));
      tick();
      check("reset_outs",
            32'({mod_en, mod_in, word_strobe, busy, underrun, done, s_ready}),
            32'h0);
    end
    src.delete();
    start = 0;
    gate = 0;
    arst_n = 1;
    for (int k = 0; k < 20; k++) tick();
    check("no_start_idle", 32'({mod_en, busy}), 32'h0);

    // directed frame table
    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 0);

    // start pulses mid-frame and at the end boundary are ignored
    run_vec(vecs[2], "pulses", 1);

    // payload withheld across the second payload slot
    src.delete();
    src.push_back(9'h101);
    gate = 1;
    frame_len = 8'd3;
    start = 1;
    begin_frame();
    tick();
    start = 0;
    pushed = 0;
    for (int k = 0; done_lat < 0 && k < 200; k++) begin
      if (!pushed && got_words.size() == 6) begin
        src.push_back(9'h0AA);
        src.push_back(9'h1FF);
        pushed = 1;
      end
      tick();
    end
    if (done_lat < 0) check("und_timeout", 32'h0, 32'h1);
    uexp[0] = PRE; uexp[1] = PRE; uexp[2] = SYN; uexp[3] = 9'h003;
    uexp[4] = 9'h101; uexp[5] = 9'h000; uexp[6] = 9'h0AA;
    uexp[7] = 9'h1AE;
    check_words("und", 7 + CS, uexp);
    check("und_en_cycles", 32'(en_cnt), 32'((7 + CS) * WC));
    check("und_flag", 32'(underrun), 32'h1);
    src.delete();
    for (int k = 0; k < 5; k++) tick();
    check("und_sticky", 32'(underrun), 32'h1);
    run_vec(vecs[0], "und_clear", 0);

    // asynchronous reset in the middle of the payload
    src.delete();
    src.push_back(9'h101);
    src.push_back(9'h0AA);
    src.push_back(9'h1FF);
    frame_len = 8'd3;
    start = 1;
    begin_frame();
    tick();
    start = 0;
    for (int k = 0; got_words.size() < 5 && k < 100; k++) tick();
    tick();
    tick();
    #2 arst_n = 0;
    #1;
    check("midrst_outs",
          32'({mod_en, mod_in, word_strobe, busy, underrun, done, s_ready}),
          32'h0);
    model_reset();
    tick();
    tick();
    arst_n = 1;
    src.delete();
    run_vec(vecs[0], "after_rst", 0);

    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      thr = 1 + (k / 300) % 4;
      gate = ($urandom_range(0, 3) < thr);
      start = ($urandom_range(0, 19) == 0);
      frame_len = 8'($urandom_range(0, 6));
      while (src.size() < 2) src.push_back(9'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
